// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and FSM state encoding
// Purpose: ALU_OP code points shared with the ALU control decoder, plus the
//          execution FSM state type used by alu_multicycle.
// Ports:   none (package).
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_EQUAL = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_UND6  = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_NOR   = 4'b1001;
  localparam logic [3:0] ALU_SUB   = 4'b1010;
  localparam logic [3:0] ALU_UND11 = 4'b1011;
  localparam logic [3:0] ALU_GE    = 4'b1100;
  localparam logic [3:0] ALU_GEU   = 4'b1101;
  localparam logic [3:0] ALU_SLT   = 4'b1110;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - operand/result handshake bundle for the ALU
// Purpose: groups the operand-side and result-side valid/ready handshakes.
// Ports (slave = ALU side):
//   in_valid_i, ALU_OP_i, A_i, B_i, out_ready_i  -> into the ALU
//   in_ready_o, out_valid_o, RESULT_o, ZERO_o    <- from the ALU
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       ALU_OP_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] RESULT_o;
  logic             ZERO_o;

  modport slave (
    input  in_valid_i, ALU_OP_i, A_i, B_i, out_ready_i,
    output in_ready_o, out_valid_o, RESULT_o, ZERO_o
  );

  modport master (
    output in_valid_i, ALU_OP_i, A_i, B_i, out_ready_i,
    input  in_ready_o, out_valid_o, RESULT_o, ZERO_o
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - one-bit-per-cycle shifter for SLL/SRL/SRA
// Purpose: holds the shift accumulator, remaining count and shift kind.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        capture a_i/op_i/shamt_i (applies the first step immediately)
//   step_i        advance one bit position and decrement the count
//   op_i          shift kind at load time
//   a_i           operand at load time
//   shamt_i       shift amount at load time
//   step_o        combinational one-bit shift of a_i (when loading) or of acc
//   last_o        the next step produces the final value
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [3:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   step_o,
  output logic               last_o
);

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   src;
  logic [3:0]         op_sel;

  // The first bit of shift happens in the accept cycle, so the stepper sees
  // the raw operand while loading and the accumulator afterwards. This keeps
  // accept-to-result latency equal to the shift amount.
  always_comb begin
    src    = load_i ? a_i  : acc_q;
    op_sel = load_i ? op_i : op_q;
    case (op_sel)
      ALU_SLL: step_o = {src[WIDTH-2:0], 1'b0};
      ALU_SRA: step_o = {src[WIDTH-1], src[WIDTH-1:1]};
      default: step_o = {1'b0, src[WIDTH-1:1]};
    endcase

    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (load_i) begin
      acc_d = step_o;
      cnt_d = shamt_i - SHAMT_W'(1);
      op_d  = op_i;
    end else if (step_i) begin
      acc_d = step_o;
      cnt_d = cnt_q - SHAMT_W'(1);
    end
  end

  assign last_o = (cnt_q == SHAMT_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= ALU_AND;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execution-stage ALU with serial shifts and valid/ready handshakes
// Purpose: single-cycle logic/arith/compare ops, bit-serial shifts, registered
//          result with zero flag for branch decisions.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   bus     alu_multicycle_if.slave: operand and result handshakes, RESULT_o, ZERO_o
//   busy_o  FSM is not idle
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  alu_multicycle_if.slave         bus,
  output logic                    busy_o
);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   op_result;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               shift_op;
  logic [WIDTH-1:0]   sh_step_val;
  logic               sh_last;

  assign shamt    = bus.B_i[SHAMT_W-1:0];
  assign accept   = bus.in_valid_i && (state_q == ST_IDLE);
  assign shift_op = is_shift_op(bus.ALU_OP_i);

  alu_serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (accept && shift_op),
    .step_i  (state_q == ST_SHIFT),
    .op_i    (bus.ALU_OP_i),
    .a_i     (bus.A_i),
    .shamt_i (shamt),
    .step_o  (sh_step_val),
    .last_o  (sh_last)
  );

  // Single-cycle op mux; compares are zero-extended to WIDTH.
  always_comb begin
    op_result = '0;
    case (bus.ALU_OP_i)
      ALU_AND:   op_result = bus.A_i & bus.B_i;
      ALU_OR:    op_result = bus.A_i | bus.B_i;
      ALU_ADD:   op_result = bus.A_i + bus.B_i;
      ALU_SUB:   op_result = bus.A_i - bus.B_i;
      ALU_XOR:   op_result = bus.A_i ^ bus.B_i;
      ALU_NOR:   op_result = ~(bus.A_i | bus.B_i);
      ALU_EQUAL: op_result = WIDTH'(bus.A_i == bus.B_i);
      ALU_GE:    op_result = WIDTH'($signed(bus.A_i) >= $signed(bus.B_i));
      ALU_GEU:   op_result = WIDTH'(bus.A_i >= bus.B_i);
      ALU_SLT:   op_result = WIDTH'($signed(bus.A_i) < $signed(bus.B_i));
      ALU_SLTU:  op_result = WIDTH'(bus.A_i < bus.B_i);
      default:   op_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!shift_op) begin
            result_d = op_result;
            state_d  = ST_DONE;
          end else if (shamt == '0) begin
            result_d = bus.A_i;
            state_d  = ST_DONE;
          end else if (shamt == SHAMT_W'(1)) begin
            // The accept-cycle step is already the whole shift.
            result_d = sh_step_val;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          result_d = sh_step_val;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.RESULT_o    = result_q;
  assign bus.ZERO_o      = (result_q == '0);
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk;
  logic rst;
  logic busy;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: measures accept-to-valid latency, checks hold under backpressure,
  // and pops the scoreboard on every result handshake.
  int          mon_lat;
  logic        mon_armed = 1'b0;
  logic        hold_ok   = 1'b0;
  logic [31:0] hold_res;
  logic        hold_zero;

  always @(negedge clk) begin
    if (rst) begin
      mon_armed = 1'b0;
      hold_ok   = 1'b0;
    end else begin
      if (mon_armed) begin
        mon_lat++;
        if (bus.out_valid_o) begin
          mon_armed = 1'b0;
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL latency: result appeared with empty scoreboard at %0t", $time);
          end else begin
            check("latency", 32'(mon_lat), 32'(sb_q[0].lat));
          end
        end
      end
      if (bus.out_valid_o) begin
        if (hold_ok) begin
          check("hold_result", bus.RESULT_o, hold_res);
          check("hold_zero", 32'(bus.ZERO_o), 32'(hold_zero));
        end
        hold_ok   = 1'b1;
        hold_res  = bus.RESULT_o;
        hold_zero = bus.ZERO_o;
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        hold_ok = 1'b0;
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL result: unexpected output %h at %0t", bus.RESULT_o, $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", bus.RESULT_o, e.res);
          check("zero", 32'(bus.ZERO_o), 32'(e.zero));
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        mon_armed = 1'b1;
        mon_lat   = 0;
      end
    end
  end

  // Issue one op, optionally hold off the consumer for 'stall' cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int stall);
    int n;
    sb_q.push_back('{res: exp_res, zero: (exp_res == 32'h0), lat: exp_lat});
    @(posedge clk); #1;
    bus.in_valid_i  = 1'b1;
    bus.ALU_OP_i    = op;
    bus.A_i         = a;
    bus.B_i         = b;
    bus.out_ready_i = (stall == 0);
    @(posedge clk); #1;
    // Operands are scrambled after acceptance; the DUT must have latched them.
    bus.in_valid_i = 1'b0;
    bus.A_i        = 32'hDEAD_BEEF;
    bus.B_i        = 32'h0BAD_F00D;
    bus.ALU_OP_i   = ALU_ADD;
    n = 0;
    while (!bus.out_valid_o && n < 100) begin
      check("busy_while_shift", 32'(busy), 32'd1);
      check("in_ready_while_shift", 32'(bus.in_ready_o), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check("wait_valid", 32'(bus.out_valid_o), 32'd1);
    for (int s = 0; s < stall; s++) begin
      check("in_ready_in_done", 32'(bus.in_ready_o), 32'd0);
      bus.in_valid_i = 1'b1;
      bus.ALU_OP_i   = ALU_OR;
      bus.A_i        = 32'h1234_5678;
      bus.B_i        = 32'h1;
      @(posedge clk); #1;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("idle_after_handshake", 32'(bus.in_ready_o), 32'd1);
    check("valid_low_after_handshake", 32'(bus.out_valid_o), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
    check({tag, "_result"}, bus.RESULT_o, 32'h0);
    check({tag, "_zero"}, 32'(bus.ZERO_o), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst             = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.ALU_OP_i    = 4'h0;
    bus.A_i         = 32'h0;
    bus.B_i         = 32'h0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    //      op         A              B              expected       lat stall
    run_op(ALU_ADD,   32'd5,         32'd7,         32'd12,         1,  0);
    run_op(ALU_SUB,   32'd9,         32'd9,         32'd0,          1,  0);
    run_op(ALU_SLT,   32'd1,         32'hFFFF_FFFF, 32'd0,          1,  0);
    run_op(ALU_SLTU,  32'd1,         32'hFFFF_FFFF, 32'd1,          1,  0);
    run_op(ALU_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000,  4,  3);
    run_op(ALU_SLL,   32'h3,         32'h20,        32'h3,          1,  0);
    run_op(ALU_SLL,   32'h1,         32'd31,        32'h8000_0000,  31, 0);
    run_op(ALU_AND,   32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200,  1,  0);
    run_op(ALU_OR,    32'hF000_0000, 32'h0000_000F, 32'hF000_000F,  1,  2);
    run_op(ALU_XOR,   32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555,  1,  0);
    run_op(ALU_NOR,   32'h0,         32'h0,         32'hFFFF_FFFF,  1,  0);
    run_op(ALU_EQUAL, 32'd7,         32'd7,         32'd1,          1,  0);
    run_op(ALU_GE,    32'hFFFF_FFFF, 32'd1,         32'd0,          1,  0);
    run_op(ALU_GEU,   32'hFFFF_FFFF, 32'd1,         32'd1,          1,  0);
    run_op(ALU_UND6,  32'd5,         32'd3,         32'd0,          1,  0);
    run_op(ALU_UND11, 32'hFFFF_FFFF, 32'd3,         32'd0,          1,  0);
    run_op(ALU_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,          1,  0);
    run_op(ALU_SRL,   32'h8000_0000, 32'd1,         32'h4000_0000,  1,  0);
    run_op(ALU_SRL,   32'hFFFF_0000, 32'd8,         32'h00FF_FF00,  8,  0);
    run_op(ALU_SRA,   32'h7FFF_0000, 32'h0000_0024, 32'h07FF_F000,  4,  0);
    run_op(ALU_SRA,   32'hC000_0000, 32'd2,         32'hF000_0000,  2,  1);

    // Abort an SRL by 31 with a reset 10 cycles in; nothing may come out.
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.ALU_OP_i   = ALU_SRL;
    bus.A_i        = 32'hF000_0000;
    bus.B_i        = 32'd31;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("abort");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) n++;
    end
    check("no_stale_result", 32'(n), 32'd0);

    run_op(ALU_ADD,   32'd100,       32'd23,        32'd123,        1,  0);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
